// File: rtl/cfu_pkg.sv
// cfu_pkg: opcodes, FSM encodings and latency constants shared by the CFU.
package cfu_pkg;
  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_DOT    = 3'd1;
  localparam logic [2:0] OP_MAC    = 3'd2;
  localparam logic [2:0] OP_ACC_RD = 3'd3;
  localparam logic [2:0] OP_ACC_WR = 3'd4;
  localparam int SHORT_LAT = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
  function automatic logic is_long(input logic [2:0] f3, input logic [6:0] f7);
    return f7 == '0 && (f3 == OP_DOT || f3 == OP_MAC);
  endfunction
endpackage

// File: rtl/cfu_simd_dot.sv
// cfu_simd_dot: signed packed-SIMD dot product with a fixed MUL_STAGES-cycle latency.
module cfu_simd_dot #(
  parameter int XLEN       = 32,
  parameter int LANE_W     = 8,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] dot_o
);
  localparam int LANES = XLEN / LANE_W;
  localparam int PW    = 2 * LANE_W;
  localparam int SW    = PW + $clog2(LANES);
  logic signed [PW-1:0] prod [LANES];
  logic signed [PW-1:0] pipe [MUL_STAGES][LANES];
  logic signed [SW-1:0] sum;
  always_comb begin
    for (int l = 0; l < LANES; l++)
      prod[l] = PW'($signed(a_i[l*LANE_W +: LANE_W])) * PW'($signed(b_i[l*LANE_W +: LANE_W]));
  end
  always_ff @(posedge clk_i) begin
    pipe[0] <= prod;
    for (int s = 1; s < MUL_STAGES; s++) pipe[s] <= pipe[s-1];
  end
  // Adder tree sits after the last register so the sum is never wider-than-needed in flops.
  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) sum = sum + SW'(pipe[MUL_STAGES-1][l]);
  end
  assign dot_o = XLEN'(sum);
endmodule

// File: rtl/cfu_simd_mac.sv
// cfu_simd_mac: CFU with scalar add, SIMD dot product and accumulator MAC behind a stall handshake.
module cfu_simd_mac
  import cfu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LANE_W     = 8,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            stall_o,
  output logic [XLEN-1:0] rslt_o
);
  localparam int CW = $clog2(MUL_STAGES + 2);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0] f3_q;
  logic [6:0] f7_q;
  logic [XLEN-1:0] s1_q, s2_q, acc_q, dot, mac, res, rslt_q;
  logic stall_q, issue, finish, legal;
  cfu_simd_dot #(.XLEN(XLEN), .LANE_W(LANE_W), .MUL_STAGES(MUL_STAGES)) u_dot (
    .clk_i(clk_i),
    .a_i  (s1_q),
    .b_i  (s2_q),
    .dot_o(dot)
  );
  assign issue  = en_i && state_q != EXEC;
  assign finish = state_q == EXEC && cnt_q == '0;
  assign legal  = f7_q == '0;
  assign mac    = acc_q + dot;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_comb state_d = state_q == EXEC ? (cnt_q == '0 ? DONE : EXEC) : (en_i ? EXEC : IDLE);
  always_comb begin
    res = !legal                  ? '0 :
          f3_q == OP_ADD          ? s1_q + s2_q :
          f3_q == OP_DOT          ? dot :
          f3_q == OP_MAC          ? mac :
          f3_q == OP_ACC_RD ||
          f3_q == OP_ACC_WR       ? acc_q : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      acc_q   <= '0;
      rslt_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      stall_q <= state_d == EXEC;
      rslt_q  <= finish ? res : '0;
      if (finish && legal && f3_q == OP_MAC)         acc_q <= mac;
      else if (finish && legal && f3_q == OP_ACC_WR) acc_q <= s1_q;
      if (issue) begin
        f3_q  <= funct3_i;
        f7_q  <= funct7_i;
        s1_q  <= src1_i;
        s2_q  <= src2_i;
        cnt_q <= is_long(funct3_i, funct7_i) ? CW'(MUL_STAGES) : CW'(SHORT_LAT - 1);
      end else if (state_q == EXEC && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end
  assign stall_o = stall_q;
  assign rslt_o  = rslt_q;
endmodule

// File: tb/tb_cfu_simd_mac.sv
// tb_cfu_simd_mac: randomized scoreboard bench for cfu_simd_mac against a lane-arithmetic model.
module tb_cfu_simd_mac;
  localparam int XLEN = 32, LANE_W = 8, MUL_STAGES = 2, LANES = XLEN / LANE_W;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, stall;
  logic [2:0] f3 = '0;
  logic [6:0] f7 = '0;
  logic [XLEN-1:0] s1 = '0, s2 = '0, rslt;
  logic [XLEN-1:0] m_acc = '0;
  logic [XLEN-1:0] exp_res[$];
  int exp_lat[$];
  int checks = 0, errors = 0;
  logic prev = 1'b0;
  int scnt = 0;

  always #5 clk = ~clk;

  cfu_simd_mac #(.XLEN(XLEN), .LANE_W(LANE_W), .MUL_STAGES(MUL_STAGES)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .funct3_i(f3), .funct7_i(f7),
    .src1_i(s1), .src2_i(s2), .stall_o(stall), .rslt_o(rslt)
  );

  function automatic logic [XLEN-1:0] ref_dot(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    longint s = 0;
    for (int l = 0; l < LANES; l++) begin
      logic signed [LANE_W-1:0] x, y;
      x = a[l*LANE_W +: LANE_W];
      y = b[l*LANE_W +: LANE_W];
      s += longint'(x) * longint'(y);
    end
    return XLEN'(s);
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle so the next call issues back-to-back.
  task automatic issue(input logic [2:0] op, input logic [6:0] fn7, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input bit poke);
    logic [XLEN-1:0] r = '0;
    bit legal = (fn7 == 7'd0);
    bit done = 1'b0;
    int lat = (legal && (op == 3'd1 || op == 3'd2)) ? 1 + MUL_STAGES : 1;
    if (legal) begin
      case (op)
        3'd0: r = a + b;
        3'd1: r = ref_dot(a, b);
        3'd2: begin m_acc = m_acc + ref_dot(a, b); r = m_acc; end
        3'd3: r = m_acc;
        3'd4: begin r = m_acc; m_acc = a; end
        default: r = '0;
      endcase
    end
    exp_res.push_back(r);
    exp_lat.push_back(lat);
    en = 1'b1; f3 = op; f7 = fn7; s1 = a; s2 = b;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      en = 1'b0; f3 = 3'($urandom); f7 = 7'($urandom); s1 = $urandom; s2 = $urandom;
      done = !stall;
      if (!done && i == 0 && poke) begin
        en = 1'b1; f3 = 3'd4; f7 = 7'd0;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: stall still %b after 20 cycles, required 0", stall);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev = 1'b0;
      scnt = 0;
    end else begin
      if (prev && !stall) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: rslt %h with no pending op", rslt);
        end else begin
          check("rslt", rslt, exp_res.pop_front());
          check("stall_cycles", XLEN'(scnt), XLEN'(exp_lat.pop_front()));
        end
      end else begin
        check("rslt_idle", rslt, '0);
      end
      scnt = stall ? scnt + 1 : 0;
      prev = stall;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_stall", XLEN'(stall), '0);
    check("reset_rslt", rslt, '0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'd0, 7'd0, 32'd5, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    issue(3'd1, 7'd0, 32'h01020304, 32'h05060708, 1'b0);
    issue(3'd1, 7'd0, 32'hFFFFFFFF, 32'h01010101, 1'b0);
    issue(3'd4, 7'd0, 32'd100, 32'd0, 1'b0);
    issue(3'd2, 7'd0, 32'h01020304, 32'h05060708, 1'b0);
    issue(3'd3, 7'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    issue(3'd4, 7'd0, 32'h7FFFFFF0, 32'd0, 1'b0);
    issue(3'd2, 7'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b0);
    issue(3'd6, 7'd0, 32'd9, 32'd9, 1'b0);
    issue(3'd0, 7'h01, 32'd9, 32'd9, 1'b0);
    issue(3'd3, 7'd0, 32'd0, 32'd0, 1'b0);
    issue(3'd2, 7'd0, 32'h80FF017F, 32'h7F80FF01, 1'b1);
    issue(3'd0, 7'd0, 32'hFFFFFFFF, 32'd2, 1'b1);
    issue(3'd3, 7'd0, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 60; k++) begin
      logic [6:0] fn7 = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      issue(3'($urandom_range(0, 7)), fn7, $urandom, $urandom, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    issue(3'd4, 7'd0, 32'd55, 32'd0, 1'b0);
    en = 1'b1; f3 = 3'd2; f7 = 7'd0; s1 = $urandom; s2 = $urandom;
    @(negedge clk);
    en = 1'b0;
    check("mid_op_stall", XLEN'(stall), XLEN'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_stall", XLEN'(stall), '0);
    check("abort_rslt", rslt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc = '0;
    issue(3'd3, 7'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_drained", XLEN'(exp_res.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
